updi_double_break: RTL and testbench

- Generates the UPDI "double break" line sequence used to resynchronise a target's UPDI interface: low for PULSE_CLK cycles, high for PULSE_CLK cycles, low for PULSE_CLK cycles, then release.
- Sits between the UPDI controller FSM and the line driver.
- The controller pulses start, waits for done, then proceeds with SYNCH/command traffic.

---
 rtl/updi_pkg.sv | 20 ++
 rtl/updi_pulse_timer.sv | 27 ++
 rtl/updi_double_break.sv | 79 +++++++
 tb/tb_updi_double_break.sv | 137 +++++++++++++
 4 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI definitions: double-break FSM states, default break length,
// and the counter-width helper used by UPDI timers.
package updi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK1 = 2'd1,
    GAP    = 2'd2,
    BREAK2 = 2'd3
  } state_t;

  // Default break phase length in clocks; parents override from clock/baud.
  localparam int UPDI_BREAK_CLK = 10;

  // Counter width able to hold 0..p, never narrower than one bit.
  function automatic int cnt_width(input int p);
    return (p < 2) ? 1 : $clog2(p + 1);
  endfunction

endpackage

// File: rtl/updi_pulse_timer.sv
// Phase timer: counts enabled edges and wraps to zero on the edge that
// completes PULSE_CLK cycles; tc flags that edge. load forces zero.
module updi_pulse_timer
  import updi_pkg::*;
#(
  parameter int PULSE_CLK = UPDI_BREAK_CLK,
  localparam int W = cnt_width(PULSE_CLK)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == W'(PULSE_CLK - 1));

  // Count while enabled; wrap on terminal count so each phase restarts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (load)  cnt <= '0;
    else if (en)    cnt <= tc ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/updi_double_break.sv
// UPDI double break generator: line low, high, low for PULSE_CLK cycles each,
// then released. busy/done/pulse are all registered.
module updi_double_break
  import updi_pkg::*;
#(
  parameter int PULSE_CLK = UPDI_BREAK_CLK
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic pulse
);

  state_t state, state_n;
  logic   busy_n, done_n, pulse_n;
  logic   tc;

  // Timer held at zero in IDLE so the first busy phase starts from 0.
  updi_pulse_timer #(.PULSE_CLK(PULSE_CLK)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == IDLE),
    .en   (state != IDLE),
    .tc   (tc)
  );

  // State and registered outputs; reset releases the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pulse <= 1'b1;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      pulse <= pulse_n;
    end
  end

  // Next state and next output values; start is ignored outside IDLE.
  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = done;
    pulse_n = pulse;
    case (state)
      IDLE: if (start) begin
        state_n = BREAK1;
        busy_n  = 1'b1;
        pulse_n = 1'b0;
        done_n  = 1'b0;
      end
      BREAK1: if (tc) begin
        state_n = GAP;
        pulse_n = 1'b1;
      end
      GAP: if (tc) begin
        state_n = BREAK2;
        pulse_n = 1'b0;
      end
      BREAK2: if (tc) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        pulse_n = 1'b1;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        pulse_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_updi_double_break.sv
// Bench for updi_double_break: two instances (PULSE_CLK=10 and 1) share
// stimulus and are compared each cycle against a position-in-sequence model.
module tb_updi_double_break;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] busy, done, pulse;

  int errors = 0;
  int checks = 0;

  // Model: pos = cycles since sequence entry (-1 when idle), plus done flag.
  int plen [2] = '{10, 1};
  int pos  [2];
  bit mdone[2];

  always #5 clk = ~clk;

  updi_double_break #(.PULSE_CLK(10)) dut10 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy[0]), .done(done[0]), .pulse(pulse[0])
  );

  updi_double_break #(.PULSE_CLK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy[1]), .done(done[1]), .pulse(pulse[1])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i]   = -1;
      mdone[i] = 1'b0;
    end
  endtask

  // Advance the model by one rising edge with the sampled start.
  task automatic model_edge(input bit s);
    for (int i = 0; i < 2; i++) begin
      if (pos[i] < 0) begin
        if (s) begin
          pos[i]   = 0;
          mdone[i] = 1'b0;
        end
      end else begin
        pos[i]++;
        if (pos[i] == 3 * plen[i]) begin
          pos[i]   = -1;
          mdone[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic eb, ep;
      eb = (pos[i] >= 0);
      ep = (pos[i] < 0) ? 1'b1 : ((pos[i] / plen[i]) == 1);
      chk($sformatf("%s.p%0d.busy", tag, plen[i]), busy[i], eb);
      chk($sformatf("%s.p%0d.done", tag, plen[i]), done[i], mdone[i]);
      chk($sformatf("%s.p%0d.pulse", tag, plen[i]), pulse[i], ep);
    end
  endtask

  // One clock: drive start, let the edge happen, check on the falling edge.
  task automatic cyc(input bit s, input string tag);
    start = s;
    @(posedge clk);
    if (rst) model_edge(s);
    else     model_reset();
    @(negedge clk);
    check_all(tag);
  endtask

  // Pull reset low between edges and check outputs right away.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset held with clock running.
    for (int k = 0; k < 4; k++) cyc(k[0], "rst_hold");
    rst = 1'b1;
    cyc(1'b0, "idle");

    // Nominal single start.
    cyc(1'b1, "nom");
    for (int k = 0; k < 35; k++) cyc(1'b0, "nom");

    // start re-asserted at edges 5 and 15 of a run.
    cyc(1'b1, "busy_start");
    for (int k = 1; k < 36; k++) cyc(k == 5 || k == 15, "busy_start");

    // Async reset mid-GAP of the long instance, then stay idle.
    cyc(1'b1, "mid_rst");
    for (int k = 1; k < 14; k++) cyc(1'b0, "mid_rst");
    async_reset("mid_rst_async");
    cyc(1'b0, "mid_rst_low");
    rst = 1'b1;
    for (int k = 0; k < 40; k++) cyc(1'b0, "post_rst");

    // start held high: back-to-back sequences.
    for (int k = 0; k < 70; k++) cyc(1'b1, "b2b");
    for (int k = 0; k < 35; k++) cyc(1'b0, "b2b_tail");

    // Random start traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_async");
        cyc(1'b0, "rnd_low");
        rst = 1'b1;
      end else begin
        cyc($urandom_range(0, 5) == 0, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
